// File: rtl/npu_conv_pkg.sv
// Shared conv-datapath types and helpers: pixel/column types, stride clamping,
// and the lane/row/column flattening rule used by the window buffer and PE array.
package npu_conv_pkg;

  localparam int unsigned PIX_DW = 8;
  localparam int unsigned COL_H  = 3;

  typedef logic [PIX_DW-1:0] pix_t;
  typedef pix_t [COL_H-1:0]  col_t;

  // Illegal strides (0 or wider than the kernel) degrade to stride 1.
  function automatic int unsigned stride_clamp(input int unsigned stride,
                                               input int unsigned k_w);
    return (stride == 0 || stride > k_w) ? 1 : stride;
  endfunction

  // Pixel index in a flattened bus: lane-major, then column, then row.
  // With k_w = 1 this is also the layout of a single column beat.
  function automatic int unsigned pix_idx(input int unsigned lane,
                                          input int unsigned row,
                                          input int unsigned col,
                                          input int unsigned k_h,
                                          input int unsigned k_w);
    return (lane * k_w + col) * k_h + row;
  endfunction

endpackage

// File: rtl/conv_window_lane.sv
// One channel lane of the window: K_W columns of K_H pixels, shifted on a shared
// enable. Column 0 is the newest column.
module conv_window_lane #(
  parameter int DW  = 8,
  parameter int K_H = 3,
  parameter int K_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    shift_i,
  input  logic [K_H*DW-1:0]       col_i,
  output logic [K_W*K_H*DW-1:0]   win_o,
  output logic [K_H*DW-1:0]       tap_new_o,
  output logic [K_H*DW-1:0]       tap_old_o
);

  logic [K_W-1:0][K_H*DW-1:0] win_q;

  // NOTE: the window array is reset on purpose: outputs must read zero after
  // reset/clear, so it cannot be left to power-up state like a plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (clear_i) begin
      win_q <= '0;
    end else if (shift_i) begin
      win_q[0] <= col_i;
      for (int j = 1; j < K_W; j++) begin
        win_q[j] <= win_q[j-1];
      end
    end
  end

  assign win_o     = win_q;
  assign tap_new_o = win_q[0];
  assign tap_old_o = win_q[K_W-1];

endmodule

// File: rtl/conv_window_shift_buf.sv
// Column-shift window buffer: accepts one image column per beat, emits K_H x K_W
// windows per lane at a runtime stride, never straddling an image row.
module conv_window_shift_buf
  import npu_conv_pkg::*;
#(
  parameter int DW  = 8,
  parameter int K_H = 3,
  parameter int K_W = 3,
  parameter int CH  = 1,
  parameter int SW  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [SW-1:0]             stride,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH*K_H*DW-1:0]      in_data,
  input  logic                      in_last,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [CH*K_H*K_W*DW-1:0]  win_data,
  output logic                      win_last,
  output logic [CH*K_H*DW-1:0]      tap_new,
  output logic [CH*K_H*DW-1:0]      tap_old
);

  localparam int CW    = $clog2(K_W + 1);
  localparam int COL_W = K_H * DW;
  localparam int WIN_W = K_W * COL_W;

  localparam logic [CW-1:0] FULL = CW'(K_W);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] ST_FILL  = 2'd0;  // fewer than K_W columns in this row
  localparam logic [1:0] ST_SKIP  = 2'd1;  // full, skipping columns for stride
  localparam logic [1:0] ST_ARMED = 2'd2;  // full, next accept emits a window
  localparam logic [1:0] ST_HOLD  = 2'd3;  // window stalled by consumer

  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] skip_q, skip_d;
  logic [CW-1:0] stride_q, stride_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic [1:0]    state;
  logic          accept, take, emit;

  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;
  assign take     = win_valid_q && win_ready;

  always_comb begin
    if (win_valid_q && !win_ready) state = ST_HOLD;
    else if (fill_q != FULL)       state = ST_FILL;
    else if (skip_q != '0)         state = ST_SKIP;
    else                           state = ST_ARMED;
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this combinational, not a latch.
  always_comb begin
    fill_d      = fill_q;
    skip_d      = skip_q;
    stride_d    = stride_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    emit        = 1'b0;

    // Stride only changes between rows so a row never mixes two strides.
    if (fill_q == '0) stride_d = CW'(stride_clamp(32'(stride), K_W));
    if (take) win_valid_d = 1'b0;

    if (accept) begin
      case (state)
        ST_FILL: begin
          fill_d = fill_q + ONE;
          emit   = (fill_q + ONE == FULL);
        end
        ST_SKIP:  skip_d = skip_q - ONE;
        ST_ARMED: emit = 1'b1;
        default:  ;
      endcase
      if (emit) begin
        win_valid_d = 1'b1;
        win_last_d  = in_last;
        skip_d      = stride_q - ONE;
      end
      // Old-row columns stay in the array; fill count alone masks them.
      if (in_last) begin
        fill_d = '0;
        skip_d = '0;
      end
    end

    if (clear) begin
      fill_d      = '0;
      skip_d      = '0;
      stride_d    = ONE;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q      <= '0;
      skip_q      <= '0;
      stride_q    <= ONE;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      skip_q      <= skip_d;
      stride_q    <= stride_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

  for (genvar l = 0; l < CH; l++) begin : g_lane
    localparam int IN_LO  = int'(pix_idx(l, 0, 0, K_H, 1)) * DW;
    localparam int WIN_LO = int'(pix_idx(l, 0, 0, K_H, K_W)) * DW;

    conv_window_lane #(
      .DW  (DW),
      .K_H (K_H),
      .K_W (K_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear),
      .shift_i   (accept),
      .col_i     (in_data[IN_LO +: COL_W]),
      .win_o     (win_data[WIN_LO +: WIN_W]),
      .tap_new_o (tap_new[IN_LO +: COL_W]),
      .tap_old_o (tap_old[IN_LO +: COL_W])
    );
  end

endmodule

// File: tb/tb_conv_window_shift_buf.sv
// Directed bench for conv_window_shift_buf: a column-level model pushes expected
// windows to a scoreboard; a negedge monitor pops them on every take.
module tb_conv_window_shift_buf;

  localparam int DW  = 8;
  localparam int K_H = 3;
  localparam int K_W = 3;
  localparam int CH  = 1;
  localparam int SW  = 2;

  typedef struct {
    logic [71:0] data;
    logic        last;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      clear;
  logic [SW-1:0]             stride;
  logic                      in_valid;
  logic                      in_ready;
  logic [CH*K_H*DW-1:0]      in_data;
  logic                      in_last;
  logic                      win_valid;
  logic                      win_ready;
  logic [CH*K_H*K_W*DW-1:0]  win_data;
  logic                      win_last;
  logic [CH*K_H*DW-1:0]      tap_new;
  logic [CH*K_H*DW-1:0]      tap_old;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference model state: columns seen in the current row and last three columns.
  int          k_in_row = 0;
  int          s_eff    = 1;
  logic [23:0] h0, h1, h2;

  conv_window_shift_buf #(
    .DW (DW), .K_H (K_H), .K_W (K_W), .CH (CH), .SW (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .stride    (stride),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_last  (win_last),
    .tap_new   (tap_new),
    .tap_old   (tap_old)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mkcol(input logic [7:0] v);
    logic [7:0] r1, r2;
    r1 = v + 8'h40;
    r2 = v + 8'h80;
    return {r2, r1, v};
  endfunction

  // A window ends at column k of a row when k >= K_W and (k - K_W) is a
  // multiple of the effective stride.
  task automatic model_col(input logic [23:0] c, input logic last);
    exp_t e;
    h2 = h1;
    h1 = h0;
    h0 = c;
    k_in_row++;
    if (k_in_row >= K_W && ((k_in_row - K_W) % s_eff) == 0) begin
      e.data = {h2, h1, h0};
      e.last = last;
      sb.push_back(e);
    end
    if (last) k_in_row = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_col(input logic [7:0] v, input logic last);
    logic acc;
    model_col(mkcol(v), last);
    in_valid = 1'b1;
    in_data  = mkcol(v);
    in_last  = last;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("accept_timeout", 128'(acc), 128'(1'b1));
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    check(tag, 128'(sb.size()), 128'(0));
  endtask

  // Scoreboard consumer: every take must match the oldest expected window.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && win_valid && win_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_window", 128'(win_valid), 128'(1'b0));
      end else begin
        e = sb.pop_front();
        check("win_data", 128'(win_data), 128'(e.data));
        check("win_last", 128'(win_last), 128'(e.last));
        check("tap_new",  128'(tap_new),  128'(e.data[23:0]));
        check("tap_old",  128'(tap_old),  128'(e.data[71:48]));
      end
    end
  end

  initial begin
    logic [71:0] held;
    rst_n     = 1'b0;
    clear     = 1'b0;
    stride    = 2'd1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    win_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_win_valid", 128'(win_valid), 128'(1'b0));
    check("rst_in_ready",  128'(in_ready),  128'(1'b1));
    check("rst_win_data",  128'(win_data),  128'(0));
    check("rst_win_last",  128'(win_last),  128'(1'b0));
    check("rst_tap_old",   128'(tap_old),   128'(0));
    rst_n = 1'b1;
    repeat (2) tick();

    // Stride 1, six-column row: windows after columns 3..6, last on the 4th
    s_eff = 1;
    for (int i = 0; i < 6; i++) send_col(8'(8'h10 + i), i == 5);
    drain("s1_drain");

    // Stride 2, seven-column row: windows after columns 3, 5, 7
    stride = 2'd2;
    s_eff  = 2;
    tick();
    for (int i = 0; i < 7; i++) send_col(8'(8'h20 + i), i == 6);
    drain("s2_drain");

    // Backpressure: window stalled for 5 cycles while a column waits
    stride    = 2'd1;
    s_eff     = 1;
    tick();
    win_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_col(8'(8'h30 + i), 1'b0);
    model_col(mkcol(8'h33), 1'b0);
    held     = sb[0].data;
    in_valid = 1'b1;
    in_data  = mkcol(8'h33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready",  128'(in_ready),  128'(1'b0));
      check("bp_win_valid", 128'(win_valid), 128'(1'b1));
      check("bp_win_data",  128'(win_data),  128'(held));
      tick();
    end
    win_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_b2b_valid", 128'(win_valid), 128'(1'b1));
    tick();
    send_col(8'h34, 1'b1);
    drain("bp_drain");

    // Row boundary: 2-column row yields nothing, next row is row-2 pixels only
    send_col(8'h40, 1'b0);
    send_col(8'h41, 1'b1);
    send_col(8'h50, 1'b0);
    send_col(8'h51, 1'b0);
    send_col(8'h52, 1'b1);
    drain("row_drain");

    // Asynchronous reset mid-row while a window is pending
    win_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_col(8'(8'h60 + i), 1'b0);
    check("valid_before_rst", 128'(win_valid), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_win_valid", 128'(win_valid), 128'(1'b0));
    check("arst_win_data",  128'(win_data),  128'(0));
    check("arst_tap_new",   128'(tap_new),   128'(0));
    check("arst_in_ready",  128'(in_ready),  128'(1'b1));
    sb.delete();
    k_in_row  = 0;
    win_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_col(8'h70, 1'b0);
    send_col(8'h71, 1'b0);
    repeat (3) tick();
    check("post_rst_no_window", 128'(win_valid), 128'(1'b0));
    drain("rst_drain");

    // Clear concurrent with an accept that would complete a window
    in_valid = 1'b1;
    in_data  = mkcol(8'h72);
    clear    = 1'b1;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    k_in_row = 0;
    @(negedge clk);
    check("clr_win_valid", 128'(win_valid), 128'(1'b0));
    check("clr_win_data",  128'(win_data),  128'(0));
    tick();
    send_col(8'h80, 1'b0);
    send_col(8'h81, 1'b0);
    send_col(8'h82, 1'b1);
    drain("clr_drain");

    // stride = 0 behaves as stride 1
    stride = 2'd0;
    s_eff  = 1;
    tick();
    for (int i = 0; i < 5; i++) send_col(8'(8'h90 + i), i == 4);
    drain("s0_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
